// File: rtl/fc_cmd_pkg.sv
// Fast-control command codes and shared constants for the scheduler and the fast_control encoder.
package fc_cmd_pkg;

    localparam int CMD_W         = 4;
    localparam int ORBIT_LEN_DEF = 3564;

    localparam logic [CMD_W-1:0] FC_CMD_BCR    = 4'd1;
    localparam logic [CMD_W-1:0] FC_CMD_L1A    = 4'd2;
    localparam logic [CMD_W-1:0] FC_CMD_CALIB  = 4'd3;
    localparam logic [CMD_W-1:0] FC_CMD_LRESET = 4'd4;

    typedef enum logic {
        IDLE,
        OFFER
    } issue_state_t;

    typedef enum logic [1:0] {
        CAL_IDLE,
        CAL_PEND,
        CAL_WAIT
    } cal_state_t;

endpackage

// File: rtl/fc_l1a_throttle.sv
// L1A bookkeeping: pending-request counter, deadtime counter, saturating drop counter and busy.
module fc_l1a_throttle #(
    parameter int L1A_DEPTH = 4
) (
    input  logic        clk_bx,
    input  logic        reset,
    input  logic        trig_req,
    input  logic        inject_req,
    input  logic        l1a_accept,
    input  logic [7:0]  cfg_deadtime,
    output logic        l1a_elig,
    output logic        busy,
    output logic [15:0] trig_dropped
);

    localparam int PW = $clog2(L1A_DEPTH + 1);
    localparam int CW = PW + 1;

    logic [PW-1:0] pend_q;
    logic [7:0]    dead_q;
    logic [CW-1:0] n_req;
    logic [CW-1:0] room;
    logic [CW-1:0] n_take;
    logic [1:0]    n_drop;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Room is judged against the count held before this cycle's acceptance.
    always_comb begin
        n_req  = CW'(trig_req) + CW'(inject_req);
        room   = CW'(L1A_DEPTH) - {1'b0, pend_q};
        n_take = (n_req > room) ? room : n_req;
        n_drop = 2'(n_req - n_take);
    end

    assign l1a_elig = (pend_q != '0) && (dead_q == 8'd0);

    always_ff @(posedge clk_bx) begin
        if (reset) begin
            pend_q       <= '0;
            dead_q       <= 8'd0;
            trig_dropped <= 16'd0;
            busy         <= 1'b0;
        end else begin
            pend_q       <= pend_q + PW'(n_take) - PW'(l1a_accept);
            trig_dropped <= sat_add16(trig_dropped, n_drop);
            busy         <= (pend_q >= PW'(L1A_DEPTH - 1)) || (dead_q != 8'd0);
            if (l1a_accept)
                dead_q <= cfg_deadtime;
            else if (dead_q != 8'd0)
                dead_q <= dead_q - 8'd1;
        end
    end

endmodule

// File: rtl/fc_cmd_scheduler.sv
// Fast-control command arbiter (BCR > L1A > LINK_RESET > CALIB) with calibration sequencing.
// Define FC_CMD_STATS_EN to add per-command accepted counters (stat_bcr/l1a/calib/lreset).
module fc_cmd_scheduler
    import fc_cmd_pkg::*;
#(
    parameter int ORBIT_LEN = ORBIT_LEN_DEF,
    parameter int L1A_DEPTH = 4
) (
    input  logic             clk_bx,
    input  logic             reset,
    input  logic             enable,
    input  logic             trig_req,
    input  logic             calib_req,
    input  logic             link_reset_req,
    input  logic [7:0]       cfg_deadtime,
    input  logic [7:0]       cfg_calib_delay,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd_code,
    input  logic             cmd_ready,
    output logic [11:0]      bx_count,
    output logic             busy,
    output logic [15:0]      trig_dropped
`ifdef FC_CMD_STATS_EN
    ,
    output logic [31:0]      stat_bcr,
    output logic [31:0]      stat_l1a,
    output logic [31:0]      stat_calib,
    output logic [31:0]      stat_lreset
`endif
);

    issue_state_t     state_q, state_d;
    cal_state_t       cal_q, cal_d;
    logic [CMD_W-1:0] code_q, code_d;
    logic [7:0]       cal_cnt_q, cal_cnt_d;
    logic             bcr_pend, lrst_pend, l1a_elig;
    logic             accept, inject;

    assign accept    = (state_q == OFFER) && cmd_ready;
    assign cmd_valid = (state_q == OFFER);
    assign cmd_code  = code_q;

    fc_l1a_throttle #(.L1A_DEPTH(L1A_DEPTH)) u_throttle (
        .clk_bx       (clk_bx),
        .reset        (reset),
        .trig_req     (trig_req),
        .inject_req   (inject),
        .l1a_accept   (accept && (code_q == FC_CMD_L1A)),
        .cfg_deadtime (cfg_deadtime),
        .l1a_elig     (l1a_elig),
        .busy         (busy),
        .trig_dropped (trig_dropped)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (enable && (bcr_pend || l1a_elig || lrst_pend || (cal_q == CAL_PEND))) begin
                    state_d = OFFER;
                    if (bcr_pend)       code_d = FC_CMD_BCR;
                    else if (l1a_elig)  code_d = FC_CMD_L1A;
                    else if (lrst_pend) code_d = FC_CMD_LRESET;
                    else                code_d = FC_CMD_CALIB;
                end
            end
            OFFER:   if (cmd_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cal_d     = cal_q;
        cal_cnt_d = cal_cnt_q;
        inject    = 1'b0;
        case (cal_q)
            CAL_IDLE: if (calib_req) cal_d = CAL_PEND;
            CAL_PEND: begin
                if (accept && (code_q == FC_CMD_CALIB)) begin
                    cal_d     = CAL_WAIT;
                    cal_cnt_d = cfg_calib_delay;
                end
            end
            CAL_WAIT: begin
                if (cal_cnt_q == 8'd0) begin
                    inject = 1'b1;
                    cal_d  = CAL_IDLE;
                end else begin
                    cal_cnt_d = cal_cnt_q - 8'd1;
                end
            end
            default: cal_d = CAL_IDLE;
        endcase
    end

    // A new orbit wins over a BCR acceptance landing on the same edge.
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            state_q   <= IDLE;
            code_q    <= '0;
            cal_q     <= CAL_IDLE;
            cal_cnt_q <= 8'd0;
            bx_count  <= 12'd0;
            bcr_pend  <= 1'b0;
            lrst_pend <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            cal_q     <= cal_d;
            cal_cnt_q <= cal_cnt_d;
            bx_count  <= (bx_count == 12'(ORBIT_LEN - 1)) ? 12'd0 : bx_count + 12'd1;
            if (bx_count == 12'(ORBIT_LEN - 1))
                bcr_pend <= 1'b1;
            else if (accept && (code_q == FC_CMD_BCR))
                bcr_pend <= 1'b0;
            if (accept && (code_q == FC_CMD_LRESET))
                lrst_pend <= 1'b0;
            else if (link_reset_req)
                lrst_pend <= 1'b1;
        end
    end

`ifdef FC_CMD_STATS_EN
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            stat_bcr    <= 32'd0;
            stat_l1a    <= 32'd0;
            stat_calib  <= 32'd0;
            stat_lreset <= 32'd0;
        end else if (accept) begin
            if (code_q == FC_CMD_BCR)    stat_bcr    <= stat_bcr + 32'd1;
            if (code_q == FC_CMD_L1A)    stat_l1a    <= stat_l1a + 32'd1;
            if (code_q == FC_CMD_CALIB)  stat_calib  <= stat_calib + 32'd1;
            if (code_q == FC_CMD_LRESET) stat_lreset <= stat_lreset + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fc_cmd_scheduler.sv
// Directed and randomized bench for fc_cmd_scheduler against a cycle-level reference model.
module tb_fc_cmd_scheduler;
    import fc_cmd_pkg::*;

    localparam int ORB = 16;
    localparam int D   = 4;

    logic             clk_bx = 1'b0;
    logic             reset = 1'b1, enable = 1'b0, trig_req = 1'b0, calib_req = 1'b0;
    logic             link_reset_req = 1'b0, cmd_ready = 1'b0;
    logic [7:0]       cfg_deadtime = 8'd0, cfg_calib_delay = 8'd0;
    logic             cmd_valid, busy;
    logic [CMD_W-1:0] cmd_code;
    logic [11:0]      bx_count;
    logic [15:0]      trig_dropped;
`ifdef FC_CMD_STATS_EN
    logic [31:0]      stat_bcr, stat_l1a, stat_calib, stat_lreset;
`endif

    fc_cmd_scheduler #(.ORBIT_LEN(ORB), .L1A_DEPTH(D)) dut (
        .clk_bx          (clk_bx),
        .reset           (reset),
        .enable          (enable),
        .trig_req        (trig_req),
        .calib_req       (calib_req),
        .link_reset_req  (link_reset_req),
        .cfg_deadtime    (cfg_deadtime),
        .cfg_calib_delay (cfg_calib_delay),
        .cmd_valid       (cmd_valid),
        .cmd_code        (cmd_code),
        .cmd_ready       (cmd_ready),
        .bx_count        (bx_count),
        .busy            (busy),
        .trig_dropped    (trig_dropped)
`ifdef FC_CMD_STATS_EN
        ,
        .stat_bcr        (stat_bcr),
        .stat_l1a        (stat_l1a),
        .stat_calib      (stat_calib),
        .stat_lreset     (stat_lreset)
`endif
    );

    always #5 clk_bx = ~clk_bx;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: pending work as plain counts, calibration as a scheduled injection edge.
    int m_bx = 0, m_l1a = 0, m_dead = 0, m_drop = 0, m_code = 0, m_inject_at = -1, cyc = 0;
    bit m_bcr = 0, m_lrst = 0, m_cal_pend = 0, m_busy = 0, m_offer = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit acc, inj, elig, n_offer, n_bcr, n_lrst, n_cal;
        int add, room, take, n_code, n_dead, n_inj_at;
        cyc++;
        if (reset) begin
            m_bx = 0; m_l1a = 0; m_dead = 0; m_drop = 0; m_code = 0; m_inject_at = -1;
            m_bcr = 0; m_lrst = 0; m_cal_pend = 0; m_busy = 0; m_offer = 0;
            return;
        end
        acc  = m_offer && cmd_ready;
        inj  = (m_inject_at == cyc);
        elig = (m_l1a > 0) && (m_dead == 0);
        add  = (trig_req ? 1 : 0) + (inj ? 1 : 0);
        room = D - m_l1a;
        take = (add < room) ? add : room;
        n_offer = m_offer; n_code = m_code;
        if (m_offer) begin
            if (cmd_ready) n_offer = 0;
        end else if (enable && (m_bcr || elig || m_lrst || m_cal_pend)) begin
            n_offer = 1;
            n_code  = m_bcr ? 1 : elig ? 2 : m_lrst ? 4 : 3;
        end
        n_dead = (acc && m_code == 2) ? int'(cfg_deadtime) : (m_dead > 0 ? m_dead - 1 : 0);
        n_bcr  = (m_bx == ORB - 1) ? 1'b1 : ((acc && m_code == 1) ? 1'b0 : m_bcr);
        n_lrst = (acc && m_code == 4) ? 1'b0 : (m_lrst | link_reset_req);
        n_cal = m_cal_pend; n_inj_at = m_inject_at;
        if (acc && m_code == 3) begin
            n_cal = 0;
            n_inj_at = cyc + int'(cfg_calib_delay) + 1;
        end else if (calib_req && !m_cal_pend && !(m_inject_at >= cyc)) begin
            n_cal = 1;
        end
        m_busy = (m_l1a >= D - 1) || (m_dead != 0);
        m_drop = (m_drop + add - take > 65535) ? 65535 : m_drop + add - take;
        m_l1a  = m_l1a + take - ((acc && m_code == 2) ? 1 : 0);
        m_bx   = (m_bx == ORB - 1) ? 0 : m_bx + 1;
        m_dead = n_dead; m_bcr = n_bcr; m_lrst = n_lrst;
        m_cal_pend = n_cal; m_inject_at = n_inj_at;
        m_offer = n_offer; m_code = n_code;
    endtask

    task automatic step();
        @(posedge clk_bx);
        model_edge();
        #1;
        chk("cmd_valid", 32'(cmd_valid), 32'(m_offer));
        chk("cmd_code", 32'(cmd_code), 32'(m_code));
        chk("bx_count", 32'(bx_count), 32'(m_bx));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("trig_dropped", 32'(trig_dropped), 32'(m_drop));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_bcr, n_l1a, n_cal, last_acc, min_gap, cal_acc, gap, waited;
        int codes[$];

        // Reset state
        reset = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_code", 32'(cmd_code), 32'd0);
        chk("rst_bx", 32'(bx_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(trig_dropped), 32'd0);
        reset = 1'b0;

        // BX wrap: one BCR per orbit, offered when bx_count reads 1
        enable = 1'b1; cmd_ready = 1'b1; n_bcr = 0;
        for (int i = 0; i < 34; i++) begin
            step();
            if (cmd_valid && cmd_code == FC_CMD_BCR) begin
                n_bcr++;
                chk("bcr_bx", 32'(bx_count), 32'd1);
            end
        end
        chk("bcr_per_orbit", 32'(n_bcr), 32'd2);

        // Deadtime spacing
        cfg_deadtime = 8'd5; n_l1a = 0; last_acc = -100; min_gap = 1000;
        for (int i = 0; i < 43; i++) begin
            trig_req = (i < 3);
            if (cmd_valid && cmd_ready && cmd_code == FC_CMD_L1A) begin
                n_l1a++;
                if (cyc + 1 - last_acc < min_gap) min_gap = cyc + 1 - last_acc;
                last_acc = cyc + 1;
            end
            step();
        end
        chk("dt_l1a_count", 32'(n_l1a), 32'd3);
        chk("dt_gap_ge6", 32'(min_gap >= 6), 32'd1);
        chk("dt_no_drop", 32'(trig_dropped), 32'd0);

        // Overflow with the encoder stalled
        reset = 1'b1; step(); reset = 1'b0;
        cfg_deadtime = 8'd0; cmd_ready = 1'b0; enable = 1'b1;
        trig_req = 1'b1;
        for (int i = 0; i < 6; i++) step();
        trig_req = 1'b0;
        step();
        chk("ovf_dropped", 32'(trig_dropped), 32'd2);
        chk("ovf_busy", 32'(busy), 32'd1);
        chk("ovf_code", 32'(cmd_code), 32'(FC_CMD_L1A));

        // Reset while a command is offered
        chk("pre_rst_valid", 32'(cmd_valid), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("midrst_valid", 32'(cmd_valid), 32'd0);
        chk("midrst_bx", 32'(bx_count), 32'd0);
        cmd_ready = 1'b1; n_l1a = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cmd_valid) n_l1a++;
        end
        chk("postrst_quiet", 32'(n_l1a), 32'd0);

        // Calibration then injected L1A; a repeat during the wait is ignored
        cfg_calib_delay = 8'd10; n_cal = 0; n_l1a = 0; cal_acc = 0; gap = 0;
        for (int i = 0; i < 40; i++) begin
            calib_req = (i == 0) || (i == 7);
            if (cmd_valid && cmd_ready && cmd_code == FC_CMD_CALIB) begin
                n_cal++; cal_acc = cyc + 1;
            end
            if (cmd_valid && cmd_ready && cmd_code == FC_CMD_L1A) begin
                n_l1a++; gap = cyc + 1 - cal_acc;
            end
            step();
        end
        calib_req = 1'b0;
        chk("cal_count", 32'(n_cal), 32'd1);
        chk("cal_l1a_count", 32'(n_l1a), 32'd1);
        chk("cal_l1a_gap", 32'(gap), 32'd13);

        // Priority and hold across an orbit wrap
        reset = 1'b1; step(); reset = 1'b0;
        enable = 1'b0; cmd_ready = 1'b0; link_reset_req = 1'b1; trig_req = 1'b1;
        step();
        link_reset_req = 1'b0; trig_req = 1'b0;
        waited = 0;
        while (bx_count != 12'd12 && waited < 40) begin
            step();
            waited++;
        end
        chk("hold_reach_bx", 32'(bx_count), 32'd12);
        enable = 1'b1;
        step();
        chk("hold_first_code", 32'(cmd_code), 32'(FC_CMD_L1A));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 32'(cmd_valid), 32'd1);
            chk("hold_code", 32'(cmd_code), 32'(FC_CMD_L1A));
        end
        cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (cmd_valid && cmd_ready) codes.push_back(int'(cmd_code));
            step();
        end
        chk("prio_count", 32'(codes.size()), 32'd3);
        if (codes.size() >= 3) begin
            chk("prio_0", 32'(codes[0]), 32'(FC_CMD_L1A));
            chk("prio_1", 32'(codes[1]), 32'(FC_CMD_BCR));
            chk("prio_2", 32'(codes[2]), 32'(FC_CMD_LRESET));
        end

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) begin
                cfg_deadtime    = 8'($urandom_range(0, 6));
                cfg_calib_delay = 8'($urandom_range(0, 12));
            end
            reset          = ($urandom_range(0, 199) == 0);
            enable         = ($urandom_range(0, 9) != 0);
            cmd_ready      = ($urandom_range(0, 2) != 0);
            trig_req       = ($urandom_range(0, 2) == 0);
            calib_req      = ($urandom_range(0, 14) == 0);
            link_reset_req = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
